// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with count, shift and parallel-load modes.
// Optional JK_BANK_PARITY_EN macro adds a registered even-parity output.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             par
);

  localparam logic [1:0] M_JK = 2'b00, M_CNT = 2'b01, M_SHF = 2'b10, M_LD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_jk;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  // Each bit evaluates its own JK rule independently.
  for (genvar i = 0; i < WIDTH; i++) begin : g_jk
    always_comb begin
      w_jk[i] = r_q[i];
      case ({J[i], K[i]})
        2'b01:   w_jk[i] = 1'b0;
        2'b10:   w_jk[i] = 1'b1;
        2'b11:   w_jk[i] = ~r_q[i];
        default: w_jk[i] = r_q[i];
      endcase
    end
  end

  always_comb begin
    w_next = r_q;
    case (mode)
      M_JK:    w_next = w_jk;
      M_CNT:   w_next = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
      M_SHF:   w_next = {r_q[WIDTH-2:0], sin};
      M_LD:    w_next = J;
      default: w_next = r_q;
    endcase
  end

  // Only a counting edge out of all-ones produces the wrap pulse.
  assign w_wrap = (mode == M_CNT) && (&r_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= RST_VAL;
      r_tc <= 1'b0;
    end else if (en) begin
      r_q  <= w_next;
      r_tc <= w_wrap;
    end
  end

`ifdef JK_BANK_PARITY_EN
  logic r_par;
  always_ff @(posedge clk) begin
    if (rst)     r_par <= ^RST_VAL;
    else if (en) r_par <= ^w_next;
  end
  assign par = r_par;
`else
  assign par = 1'b0;
`endif

  assign q  = r_q;
  assign qn = ~r_q;
  assign tc = r_tc;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: driver pushes model results, monitor pops and compares.
// Two instances: RST_VAL=0 and RST_VAL=8'h3C, fed identical stimulus.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst, en, sin;
  logic [1:0] mode;
  logic [7:0] J, K;
  logic [7:0] q0, qn0, q1, qn1;
  logic       tc0, par0, tc1, par1;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .sin(sin),
    .q(q0), .qn(qn0), .tc(tc0), .par(par0));

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .sin(sin),
    .q(q1), .qn(qn1), .tc(tc1), .par(par1));

  typedef struct {
    int    q0, q1;
    bit    tc0, tc1, par0, par1;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   nvec  = 0;
  int   nfail = 0;

  // Reference state, kept as plain integers.
  int   mq[2];
  bit   mtc[2];
  int   rstv[2] = '{0, 'h3C};

  function automatic int model_next(int q, int m, int j, int k, int s);
    int r;
    case (m)
      0: begin
        r = 0;
        for (int i = 0; i < 8; i++) begin
          int qb = (q >> i) & 1;
          int jb = (j >> i) & 1;
          int kb = (k >> i) & 1;
          int nb;
          if (jb == 0 && kb == 0)      nb = qb;
          else if (jb == 0 && kb == 1) nb = 0;
          else if (jb == 1 && kb == 0) nb = 1;
          else                         nb = 1 - qb;
          r += nb << i;
        end
      end
      1:       r = (q + 1) % 256;
      2:       r = (q * 2 + s) % 256;
      default: r = j;
    endcase
    return r;
  endfunction

  function automatic bit model_par(int q);
`ifdef JK_BANK_PARITY_EN
    return bit'($countones(q[7:0]) % 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit r, input bit e, input int m, input int j,
                      input int k, input bit s, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = 2'(m); J = 8'(j); K = 8'(k); sin = s;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        mq[d]  = rstv[d];
        mtc[d] = 1'b0;
      end else if (e) begin
        mtc[d] = (m == 1) && (mq[d] == 255);
        mq[d]  = model_next(mq[d], m, j, k, int'(s));
      end
    end
    x.q0 = mq[0]; x.q1 = mq[1];
    x.tc0 = mtc[0]; x.tc1 = mtc[1];
    x.par0 = model_par(mq[0]); x.par1 = model_par(mq[1]);
    x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk({me.tag, " q0"},   int'(q0),   me.q0);
      chk({me.tag, " qn0"},  int'(qn0),  (~me.q0) & 'hFF);
      chk({me.tag, " tc0"},  int'(tc0),  int'(me.tc0));
      chk({me.tag, " par0"}, int'(par0), int'(me.par0));
      chk({me.tag, " q1"},   int'(q1),   me.q1);
      chk({me.tag, " qn1"},  int'(qn1),  (~me.q1) & 'hFF);
      chk({me.tag, " tc1"},  int'(tc1),  int'(me.tc1));
      chk({me.tag, " par1"}, int'(par1), int'(me.par1));
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; J = '0; K = '0; sin = 1'b0;
    mq = '{0, 0}; mtc = '{1'b0, 1'b0};

    // JK set/clear, toggle, hold
    step(1, 0, 0, 0,    0,    0, "rst");
    step(0, 1, 0, 'hF0, 'h0F, 0, "jk_setclr");
    step(0, 1, 0, 'hFF, 'hFF, 0, "jk_toggle");
    step(0, 1, 0, 0,    0,    0, "jk_hold");
    // count across the wrap, then hold with en low
    step(0, 1, 3, 'hFE, 0,    0, "load_fe");
    step(0, 1, 1, 0,    0,    0, "cnt_ff");
    step(0, 1, 1, 0,    0,    0, "cnt_wrap");
    step(0, 0, 1, 0,    0,    0, "en_off1");
    step(0, 0, 1, 0,    0,    0, "en_off2");
    step(0, 1, 1, 0,    0,    0, "cnt_01");
    // shift then load
    step(1, 1, 0, 0,    0,    0, "rst2");
    step(0, 1, 2, 0,    0,    1, "shf1");
    step(0, 1, 2, 0,    0,    0, "shf2");
    step(0, 1, 2, 0,    0,    1, "shf3");
    step(0, 1, 2, 0,    0,    1, "shf4");
    step(0, 1, 3, 'hA5, 'h5A, 0, "load_a5");
    // reset coincident with a wrap
    step(0, 1, 3, 'hFF, 0,    0, "load_ff");
    step(1, 1, 1, 0,    0,    0, "rst_wrap");
    // passing through all-ones outside count mode keeps tc low
    step(0, 1, 3, 'hFF, 0,    0, "ld_ff_notc");
    step(0, 1, 2, 0,    0,    1, "shf_ff_notc");
    // parity cases
    step(0, 1, 3, 'h07, 0,    0, "par_load07");
    step(0, 1, 0, 'h01, 'h01, 0, "par_tgl0");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), "rand");
    end
    // dense counting to hit the wrap under random enable
    step(0, 1, 3, 'hFC, 0, 0, "load_fc");
    for (int n = 0; n < 12; n++)
      step(0, bit'($urandom_range(0, 1)), 1, 0, 0, 0, "rand_cnt");

    repeat (4) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of JK bits (legal range 2..32).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  update enable; low = hold all state.
REQ-006 SHALL have port mode  input  2  operating mode: 00 JK, 01 count, 10 shift, 11 load.
REQ-007 SHALL have port J  input  WIDTH  per-bit J; also the load data in mode 11.
REQ-008 SHALL have port K  input  WIDTH  per-bit K.
REQ-009 SHALL have port sin  input  1  serial input for shift mode.
REQ-010 SHALL have port q  output  WIDTH  registered state.
REQ-011 SHALL have port qn  output  WIDTH  combinational ~q.
REQ-012 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-013 SHALL have port par  output  1  registered even-parity of q (see Configuration).

Function
REQ-014 All q/tc/par updates SHALL occur only on rising clk; latency from inputs to q is exactly one edge.
REQ-015 Priority at each edge SHALL be rst > en > mode.
REQ-016 With en=0, q, tc and par SHALL hold; tc SHALL not re-pulse.
REQ-017 Mode 00: each bit i SHALL follow JK rule on {J[i],K[i]}: 00 hold, 01 clear, 10 set, 11 toggle; bits independent.
REQ-018 Mode 01: q SHALL increment by 1 modulo 2^WIDTH per enabled edge; J, K, sin ignored.
REQ-019 Mode 01: tc SHALL be 1 for exactly the cycle after an enabled edge at which q wraps from all-ones to zero; otherwise 0.
REQ-020 In modes 00, 10, 11 tc SHALL be 0 after every enabled edge, including when q passes through all-ones.
REQ-021 Mode 10: q SHALL become {q[WIDTH-2:0], sin}; q[WIDTH-1] is discarded.
REQ-022 Mode 11: q SHALL become J; K ignored.
REQ-023 Mode changes SHALL take effect on the same edge they are sampled; no pipeline or internal state other than q, tc, par.
REQ-024 qn SHALL equal ~q at all times, including during and after reset.

Reset
REQ-025 On a rising edge with rst=1, q SHALL become RST_VAL and tc SHALL become 0, regardless of en, mode, J, K, sin.
REQ-026 Reset asserted mid-count or mid-shift SHALL discard the operation in progress; no tc pulse for a wrap coincident with reset.
REQ-027 Before the first reset edge, outputs are undefined; benches SHALL not check them.

Configuration
REQ-028 Macro JK_BANK_PARITY_EN defined: par SHALL be registered as XOR-reduction of next q on every edge that updates q; reset value ^RST_VAL; held when en=0.
REQ-029 Macro JK_BANK_PARITY_EN undefined: par port SHALL still exist, tied to constant 0, with no parity logic synthesised.

Verification (WIDTH=8, RST_VAL=0 unless stated)
REQ-030 rst=1 one edge, then mode=00, J=8'hF0 K=8'h0F, then J=K=8'hFF, then J=K=0 -> q=F0, then 0F, then holds 0F; qn=F0 at the end.
REQ-031 Mode 01 from q=8'hFE, en=1, three edges -> q=FF, 00, 01; tc=0,1,0; toggle en=0 for two edges after 00 -> q and tc hold.
REQ-032 Mode 10, q=00, sin pattern 1,0,1,1 -> q=01, 02, 05, 0B; then mode 11 J=8'hA5 -> q=A5.
REQ-033 Counting with q=FF and rst=1 on the wrap edge -> q=00, tc=0 next cycle; RST_VAL=8'h3C instance -> q=3C after reset.
REQ-034 JK_BANK_PARITY_EN defined: load 8'h07 -> par=1, toggle bit0 via J=K=8'h01 -> q=06, par=0; macro undefined -> par=0 throughout.
